// File: rtl/muldiv_arb_pkg.sv
// Shared types for the HI/LO multiply/divide arbiter and its datapath.
package muldiv_arb_pkg;

  localparam int unsigned NumPipes = 2;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_MTHI = 3'd1,
    OP_MTLO = 3'd2,
    OP_MUL  = 3'd3,
    OP_MADD = 3'd4,
    OP_DIV  = 3'd5
  } muldiv_op_t;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } muldiv_state_t;

  // Ops a pipe may present while its valid bit is set.
  function automatic logic op_is_legal(muldiv_op_t op);
    return op inside {OP_MTHI, OP_MTLO, OP_MUL, OP_MADD, OP_DIV};
  endfunction

endpackage

// File: rtl/muldiv_arb_if.sv
// Request/grant bundle between the two execute pipes and the HI/LO arbiter.
interface muldiv_arb_if
  import muldiv_arb_pkg::*;
();

  logic [NumPipes-1:0] req_valid;
  muldiv_op_t          req_op [NumPipes];
  logic [NumPipes-1:0] req_u;
  logic [31:0]         req_a  [NumPipes];
  logic [31:0]         req_b  [NumPipes];
  logic [NumPipes-1:0] req_ready;

  modport master (
    output req_valid, req_op, req_u, req_a, req_b,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_op, req_u, req_a, req_b,
    output req_ready
  );

endinterface

// File: rtl/muldiv_calc.sv
// Combinational HI/LO result for MUL, MADD and DIV from latched operands.
module muldiv_calc
  import muldiv_arb_pkg::*;
(
  input  muldiv_op_t  op_i,
  input  logic        u_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [31:0] next_hi_o,
  output logic [31:0] next_lo_o
);

  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic [63:0] acc;

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  // One 64-bit multiplier serves both signednesses: the low 64 bits of the
  // product of the extended operands are exact either way.
  always_comb begin
    a_ext = {{32{a_i[31] & ~u_i}}, a_i};
    b_ext = {{32{b_i[31] & ~u_i}}, b_i};
    prod  = a_ext * b_ext;
    acc   = {hi_i, lo_i} + prod;
  end

  // Signed divide on magnitudes; quotient sign is the xor, remainder follows dividend.
  always_comb begin
    a_neg  = a_i[31] & ~u_i;
    b_neg  = b_i[31] & ~u_i;
    a_mag  = a_neg ? (32'd0 - a_i) : a_i;
    b_mag  = b_neg ? (32'd0 - b_i) : b_i;
    // Keep the divider well-defined; the zero-divisor result is overridden below.
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quot   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem    = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  // Select the write-back value per op.
  always_comb begin
    next_hi_o = hi_i;
    next_lo_o = lo_i;
    unique case (op_i)
      OP_MUL: begin
        next_hi_o = prod[63:32];
        next_lo_o = prod[31:0];
      end
      OP_MADD: begin
        next_hi_o = acc[63:32];
        next_lo_o = acc[31:0];
      end
      OP_DIV: begin
        if (b_i == 32'd0) begin
          next_hi_o = a_i;
          next_lo_o = 32'hFFFF_FFFF;
        end else if (!u_i && (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF)) begin
          next_hi_o = 32'd0;
          next_lo_o = 32'h8000_0000;
        end else begin
          next_hi_o = rem;
          next_lo_o = quot;
        end
      end
      default: begin
        next_hi_o = hi_i;
        next_lo_o = lo_i;
      end
    endcase
  end

endmodule

// File: rtl/muldiv_arb.sv
// Arbiter and sequencer for the shared HI/LO multiply/divide unit; owns HI/LO.
module muldiv_arb
  import muldiv_arb_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 35,
  parameter int unsigned CNT_WIDTH  = 6
) (
  input  logic         clock,
  input  logic         reset,
  muldiv_arb_if.slave  req,
  input  logic         flush,
  output logic [31:0]  hi,
  output logic [31:0]  lo,
  output logic         busy,
  output logic         done
);

  localparam logic [CNT_WIDTH-1:0] MulLast = CNT_WIDTH'(MUL_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DivLast = CNT_WIDTH'(DIV_CYCLES - 1);

  muldiv_state_t        state_q, state_d;
  muldiv_op_t           op_q, op_d;
  logic                 u_q, u_d;
  logic [31:0]          a_q, a_d;
  logic [31:0]          b_q, b_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [31:0]          hi_q, hi_d;
  logic [31:0]          lo_q, lo_d;
  logic                 done_q, done_d;

  logic [NumPipes-1:0]  grant;
  logic                 sel;
  muldiv_op_t           acc_op;
  logic                 acc_u;
  logic [31:0]          acc_a;
  logic [31:0]          acc_b;
  logic [31:0]          calc_hi;
  logic [31:0]          calc_lo;

  muldiv_calc u_calc (
    .op_i      (op_q),
    .u_i       (u_q),
    .a_i       (a_q),
    .b_i       (b_q),
    .hi_i      (hi_q),
    .lo_i      (lo_q),
    .next_hi_o (calc_hi),
    .next_lo_o (calc_lo)
  );

  // Fixed-priority grant: pipe 0 is the older instruction and always wins.
  always_comb begin
    grant = '0;
    if ((state_q == MD_IDLE) && !flush) begin
      grant = {req.req_valid[1] & ~req.req_valid[0], req.req_valid[0]};
    end
    req.req_ready = grant;
    sel    = grant[1];
    acc_op = req.req_op[sel];
    acc_u  = req.req_u[sel];
    acc_a  = req.req_a[sel];
    acc_b  = req.req_b[sel];
  end

  // Sequencer next state: accept in IDLE, count down in RUN, write on the last cycle.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    u_d     = u_q;
    a_d     = a_q;
    b_d     = b_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      MD_IDLE: begin
        if (|grant) begin
          unique case (acc_op)
            OP_MTHI: hi_d = acc_a;
            OP_MTLO: lo_d = acc_a;
            OP_MUL, OP_MADD, OP_DIV: begin
              op_d    = acc_op;
              u_d     = acc_u;
              a_d     = acc_a;
              b_d     = acc_b;
              count_d = (acc_op == OP_DIV) ? DivLast : MulLast;
              state_d = MD_RUN;
            end
            default: ;
          endcase
        end
      end
      MD_RUN: begin
        // Flush beats completion, even on the final count.
        if (flush) begin
          state_d = MD_IDLE;
        end else if (count_q == '0) begin
          hi_d    = calc_hi;
          lo_d    = calc_lo;
          done_d  = 1'b1;
          state_d = MD_IDLE;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // State and architectural register update with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= MD_IDLE;
      op_q    <= OP_NONE;
      u_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      u_q     <= u_d;
      a_q     <= a_d;
      b_q     <= b_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q == MD_RUN);
  assign done = done_q;

  a_legal_op0 : assert property (@(posedge clock) disable iff (reset)
    req.req_valid[0] |-> op_is_legal(req.req_op[0]));
  a_legal_op1 : assert property (@(posedge clock) disable iff (reset)
    req.req_valid[1] |-> op_is_legal(req.req_op[1]));

endmodule

// File: tb/tb_muldiv_arb.sv
// Self-checking bench for muldiv_arb: vector table plus hand-written corner sequences.
module tb_muldiv_arb;
  import muldiv_arb_pkg::*;

  localparam int unsigned MulN = 5;
  localparam int unsigned DivN = 35;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  muldiv_arb_if intf ();

  muldiv_arb #(
    .MUL_CYCLES (MulN),
    .DIV_CYCLES (DivN),
    .CNT_WIDTH  (6)
  ) dut (
    .clock (clock),
    .reset (reset),
    .req   (intf),
    .flush (flush),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb [$];

  typedef struct {
    int          pipe;
    muldiv_op_t  op;
    logic        u;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi0;
    logic [31:0] lo0;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    intf.req_valid = '0;
    intf.req_u     = '0;
    for (int i = 0; i < NumPipes; i++) begin
      intf.req_op[i] = OP_NONE;
      intf.req_a[i]  = '0;
      intf.req_b[i]  = '0;
    end
  endtask

  task automatic drive(input int p, input muldiv_op_t op, input logic u,
                       input logic [31:0] a, input logic [31:0] b);
    intf.req_valid[p] = 1'b1;
    intf.req_op[p]    = op;
    intf.req_u[p]     = u;
    intf.req_a[p]     = a;
    intf.req_b[p]     = b;
  endtask

  task automatic mt_write(input int p, input muldiv_op_t op, input logic [31:0] v,
                          input string nm);
    drive(p, op, 1'b0, v, 32'd0);
    #1;
    chk({nm, " ready"}, 64'(intf.req_ready), (p == 0) ? 64'd1 : 64'd2);
    step();
    idle_inputs();
    if (op == OP_MTHI) chk(nm, 64'(hi), 64'(v));
    else chk(nm, 64'(lo), 64'(v));
  endtask

  task automatic run_op(input int p, input muldiv_op_t op, input logic u,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string nm);
    int n;
    int cyc;
    int bcnt;
    n    = (op == OP_DIV) ? DivN : MulN;
    cyc  = 1;
    bcnt = 0;
    sb.push_back(exp);
    drive(p, op, u, a, b);
    #1;
    chk({nm, " ready"}, 64'(intf.req_ready), (p == 0) ? 64'd1 : 64'd2);
    step();
    idle_inputs();
    while (!done && cyc < 100) begin
      if (busy) bcnt++;
      step();
      cyc++;
    end
    chk({nm, " latency"}, 64'(cyc), 64'(n + 1));
    chk({nm, " busy cycles"}, 64'(bcnt), 64'(n));
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s scoreboard: got empty queue want entry", nm);
    end else begin
      chk({nm, " hilo"}, {hi, lo}, sb.pop_front());
    end
    step();
    chk({nm, " done pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{0, OP_MUL,  1'b0, 32'hFFFF_FFFF, 32'd2,        32'd0, 32'd0,
                 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[1]  = '{1, OP_MUL,  1'b1, 32'hFFFF_FFFF, 32'd2,        32'd0, 32'd0,
                 64'h0000_0001_FFFF_FFFE};
    vecs[2]  = '{0, OP_MADD, 1'b1, 32'd3,         32'd4,        32'd0, 32'hFFFF_FFFF,
                 64'h0000_0001_0000_000B};
    vecs[3]  = '{0, OP_MADD, 1'b0, 32'hFFFF_FFFF, 32'd1,        32'd0, 32'd0,
                 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[4]  = '{0, OP_DIV,  1'b0, 32'hFFFF_FFF9, 32'd2,        32'd0, 32'd0,
                 64'hFFFF_FFFF_FFFF_FFFD};
    vecs[5]  = '{1, OP_DIV,  1'b0, 32'd5,         32'd0,        32'd0, 32'd0,
                 64'h0000_0005_FFFF_FFFF};
    vecs[6]  = '{0, OP_DIV,  1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'd1,
                 64'h0000_0000_8000_0000};
    vecs[7]  = '{0, OP_DIV,  1'b1, 32'hFFFF_FFF9, 32'd2,        32'd0, 32'd0,
                 64'h0000_0001_7FFF_FFFC};
    vecs[8]  = '{0, OP_DIV,  1'b0, 32'd7,         32'hFFFF_FFFE, 32'd0, 32'd0,
                 64'h0000_0001_FFFF_FFFD};
    vecs[9]  = '{1, OP_MUL,  1'b0, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0,
                 64'h4000_0000_0000_0000};
    vecs[10] = '{0, OP_DIV,  1'b1, 32'd0,         32'd0,        32'd9, 32'd9,
                 64'h0000_0000_FFFF_FFFF};
    vecs[11] = '{0, OP_MADD, 1'b0, 32'd2,         32'hFFFF_FFFD, 32'd0, 32'd10,
                 64'h0000_0000_0000_0004};
    vecs[12] = '{1, OP_MADD, 1'b1, 32'd1,         32'd1,        32'hFFFF_FFFF, 32'hFFFF_FFFF,
                 64'h0000_0000_0000_0000};

    reset = 1'b1;
    flush = 1'b0;
    idle_inputs();
    repeat (2) step();
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset ready", 64'(intf.req_ready), 64'd0);
    reset = 1'b0;
    step();

    // Both pipes request at once: pipe 0 first, pipe 1 the next cycle.
    drive(0, OP_MTHI, 1'b0, 32'h1234, 32'd0);
    drive(1, OP_MTLO, 1'b0, 32'h5678, 32'd0);
    #1;
    chk("dual ready first", 64'(intf.req_ready), 64'd1);
    step();
    intf.req_valid[0] = 1'b0;
    chk("dual hi", 64'(hi), 64'h1234);
    chk("dual busy", 64'(busy), 64'd0);
    #1;
    chk("dual ready second", 64'(intf.req_ready), 64'd2);
    step();
    idle_inputs();
    chk("dual lo", 64'(lo), 64'h5678);
    chk("dual done", 64'(done), 64'd0);

    // Vector table: preload HI/LO, issue one op, check result and timing.
    for (int i = 0; i < 13; i++) begin
      mt_write(0, OP_MTHI, vecs[i].hi0, $sformatf("v%0d pre hi", i));
      mt_write(0, OP_MTLO, vecs[i].lo0, $sformatf("v%0d pre lo", i));
      run_op(vecs[i].pipe, vecs[i].op, vecs[i].u, vecs[i].a, vecs[i].b, vecs[i].exp,
             $sformatf("v%0d", i));
    end

    // A waiting request is held off through RUN and granted in the done cycle.
    mt_write(0, OP_MTHI, 32'd0, "hold pre hi");
    mt_write(0, OP_MTLO, 32'd0, "hold pre lo");
    sb.push_back(64'd42);
    drive(0, OP_MUL, 1'b0, 32'd6, 32'd7);
    step();
    drive(0, OP_MTHI, 1'b0, 32'h99, 32'd0);
    for (int k = 1; k <= MulN; k++) begin
      #1;
      chk($sformatf("hold busy c%0d", k), 64'(busy), 64'd1);
      chk($sformatf("hold ready c%0d", k), 64'(intf.req_ready), 64'd0);
      step();
    end
    chk("hold done", 64'(done), 64'd1);
    chk("hold hilo", {hi, lo}, sb.pop_front());
    #1;
    chk("hold ready at done", 64'(intf.req_ready), 64'd1);
    step();
    idle_inputs();
    chk("hold mthi", 64'(hi), 64'h99);
    chk("hold done clear", 64'(done), 64'd0);

    // Flush mid-RUN, flush in IDLE, and flush on the final count.
    mt_write(0, OP_MTHI, 32'hAAAA, "fl pre hi");
    mt_write(0, OP_MTLO, 32'hBBBB, "fl pre lo");
    drive(0, OP_DIV, 1'b0, 32'd100, 32'd7);
    step();
    idle_inputs();
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl mid busy", 64'(busy), 64'd0);
    chk("fl mid done", 64'(done), 64'd0);
    chk("fl mid hilo", {hi, lo}, 64'h0000_AAAA_0000_BBBB);
    flush = 1'b1;
    drive(1, OP_MTLO, 1'b0, 32'h77, 32'd0);
    #1;
    chk("fl idle ready", 64'(intf.req_ready), 64'd0);
    step();
    flush = 1'b0;
    idle_inputs();
    chk("fl idle lo", 64'(lo), 64'hBBBB);
    drive(0, OP_DIV, 1'b0, 32'd100, 32'd7);
    step();
    idle_inputs();
    repeat (DivN - 1) step();
    chk("fl last busy", 64'(busy), 64'd1);
    flush = 1'b1;
    drive(1, OP_MTLO, 1'b0, 32'h5A5A, 32'd0);
    #1;
    chk("fl last ready", 64'(intf.req_ready), 64'd0);
    step();
    flush = 1'b0;
    chk("fl last busy after", 64'(busy), 64'd0);
    chk("fl last done", 64'(done), 64'd0);
    chk("fl last hilo", {hi, lo}, 64'h0000_AAAA_0000_BBBB);
    #1;
    chk("fl regrant ready", 64'(intf.req_ready), 64'd2);
    step();
    idle_inputs();
    chk("fl regrant lo", 64'(lo), 64'h5A5A);
    chk("fl regrant done", 64'(done), 64'd0);

    // Reset in the middle of a divide.
    drive(0, OP_DIV, 1'b0, 32'd100, 32'd7);
    step();
    idle_inputs();
    repeat (5) step();
    reset = 1'b1;
    step();
    chk("rst mid busy", 64'(busy), 64'd0);
    chk("rst mid hilo", {hi, lo}, 64'd0);
    drive(0, OP_MTHI, 1'b0, 32'h33, 32'd0);
    #1;
    chk("rst mid ready", 64'(intf.req_ready), 64'd1);
    idle_inputs();
    reset = 1'b0;
    repeat (DivN + 2) begin
      step();
      if (done) chk("rst mid stale done", 64'(done), 64'd0);
    end
    chk("rst mid idle", 64'(busy), 64'd0);

    chk("scoreboard empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_arb.md
# muldiv_arb

Arbiter and sequencer for the shared HI/LO multiply/divide resource in the dual-issue execute stage. Accepts HI/LO-writing requests from both execute pipes, grants one at a time in program order, and runs the multi-cycle MUL/MADD/DIV sequence. Owns the architectural HI/LO registers. Exports busy/done so decode can interlock MFHI/MFLO and later muldiv ops.

## Interface
Parameters:
- MUL_CYCLES, 5, RUN cycles for MUL/MADD (>=1)
- DIV_CYCLES, 35, RUN cycles for DIV (>=MUL_CYCLES)
- CNT_WIDTH, 6, countdown width; must hold DIV_CYCLES-1

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  2  per-pipe request; bit 0 = pipe 0 = older instruction
- req_op  in  2 x muldiv_op_t  per-pipe op; only OP_MTHI, OP_MTLO, OP_MUL, OP_MADD, OP_DIV legal with valid
- req_u  in  2  per-pipe unsigned flag
- req_a, req_b  in  2 x 32  per-pipe operands
- req_ready  out  2  one-hot grant; request accepted in a cycle where valid & ready
- flush  in  1  kill in-flight op, no HI/LO update
- hi, lo  out  32 each  architectural HI/LO
- busy  out  1  RUN state active
- done  out  1  one-cycle pulse, the cycle HI/LO first show a MUL/MADD/DIV result

## Operation
- States: IDLE, RUN. Reset -> IDLE, hi=lo=0, busy=0, done=0, req_ready=0, count=0.
- IDLE grant: req_ready = {valid[1] & ~valid[0], valid[0]} combinationally, masked by ~flush. Pipe 0 always wins; pipe 1 holds until pipe 0 idle.
- MTHI/MTLO accept: hi (or lo) <= req_a at edge; stay IDLE; no busy, no done.
- MUL/MADD/DIV accept: latch op, u, a, b; count <= N-1 (N = MUL_CYCLES or DIV_CYCLES); -> RUN.
- RUN: req_ready=0; count decrements. When count==0: write {hi,lo}, -> IDLE, done=1 next cycle.
- Result rules, computed from latched operands and current hi/lo at write edge:
  - MUL: 64-bit product, signed when u=0.
  - MADD: {hi,lo} + product, modulo 2^64.
  - DIV: lo=quotient, hi=remainder, truncating toward zero; remainder sign follows dividend.
  - DIV by zero: lo=32'hFFFFFFFF, hi=a.
  - Signed 0x80000000/-1: lo=0x80000000, hi=0.
- flush: in RUN -> IDLE next edge, HI/LO unchanged, no done. Flush on the count==0 cycle wins: no write. In IDLE, suppresses grant.
- A request arriving the cycle RUN finishes is not granted; earliest grant is the first IDLE cycle.
- reset mid-RUN: abandons op; reset values next cycle.
- Illegal op with valid: assertion failure; RTL behaviour undefined.

## Timing
- Accept in cycle t (N-cycle op): busy high t+1..t+N; new hi/lo and done visible in t+N+1. Next grant earliest t+N+1.
- MTHI/MTLO accepted in t: visible t+1; a second request (either pipe) can be granted in t+1.
- hi/lo outputs are registered, no combinational path from req_*.
- req_ready depends combinationally on req_valid, flush and state only.

## Structure
- pipTypes: add muldiv_state_t {MD_IDLE, MD_RUN}; reuse existing muldiv_op_t.
- Sub-module muldiv_calc: combinational {next_hi,next_lo} from op, u, a, b, hi, lo, including div-by-zero and overflow rules. Sequencer, arbiter, counter and HI/LO registers stay in muldiv_arb.

## Test plan
- Reset then MUL pipe 0, a=0xFFFFFFFF, b=2, u=0 -> busy cycles t+1..t+5; t+6 hi=0xFFFFFFFF, lo=0xFFFFFFFE, done pulse 1 cycle.
- Both pipes valid in one cycle, pipe 0 MTHI a=0x1234, pipe 1 MTLO a=0x5678 -> ready=01 then 10; hi=0x1234 at t+1, lo=0x5678 at t+2.
- MADD u=1 a=3 b=4 with hi=0, lo=0xFFFFFFFF -> after 5 RUN cycles hi=1, lo=0x0000000B.
- DIV u=0 a=-7 b=2 -> t+36 lo=0xFFFFFFFD, hi=0xFFFFFFFF; a=5 b=0 -> lo=0xFFFFFFFF, hi=5.
- DIV accepted, flush on RUN cycle 10, then flush on count==0 cycle of a second DIV -> HI/LO unchanged, no done, IDLE next cycle; new grant in first IDLE cycle.
- Reset asserted mid-RUN -> next cycle busy=0, hi=lo=0, req_ready follows valid.
